// File: rtl/binconv_pkg.sv
// -----------------------------------------------------------------------------
// binconv_pkg
// Shared types and helpers for the binary convolution stream engine.
//   state_t      : engine sequencing states (LOAD, CONV, DONE)
//   MODE_AND     : match function is AND (popcount of set/set pairs)
//   MODE_XNOR    : match function is XNOR (count of equal pairs)
//   count_width  : bits needed to hold a match count of 0..k*k exactly
// -----------------------------------------------------------------------------
package binconv_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_AND  = 1'b0;
    localparam logic MODE_XNOR = 1'b1;

    function automatic int count_width(input int k);
        return $clog2(k * k + 1);
    endfunction

endpackage

// File: rtl/binconv_window_pop.sv
// -----------------------------------------------------------------------------
// binconv_window_pop
// Combinational match counter for one K x K window.
// Ports:
//   win   in  K*K  window pixels, bit i*K+j = window row i, column j
//   kern  in  K*K  kernel, same bit ordering as win
//   mode  in  1    MODE_AND or MODE_XNOR
//   count out CW   number of matching positions, 0..K*K
// -----------------------------------------------------------------------------
module binconv_window_pop
    import binconv_pkg::*;
#(
    parameter int K  = 3,
    parameter int CW = count_width(K)
) (
    input  logic [K*K-1:0] win,
    input  logic [K*K-1:0] kern,
    input  logic           mode,
    output logic [CW-1:0]  count
);

    logic [K*K-1:0] match;

    always_comb begin
        match = (mode == MODE_XNOR) ? ~(win ^ kern) : (win & kern);
        count = '0;
        // Linear sum of single-bit terms; synthesis rebalances it into a tree.
        for (int i = 0; i < K * K; i++) begin
            count = count + CW'(match[i]);
        end
    end

endmodule

// File: rtl/binconv_stream_engine.sv
// -----------------------------------------------------------------------------
// binconv_stream_engine
// Streams an IMG_H x IMG_W binary image in row by row, then emits the valid
// (no padding) K x K binary convolution as per-window match counts in
// row-major order over a valid/ready port.
//
// Optional build macro: THRESH_EN
//   defined   : out_bit = (count >= thresh), thresh captured on entry to CONV
//   undefined : thresh is ignored and out_bit is tied to 0
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   row_valid/ready   image row handshake (ready only while loading)
//   row_data          pixel row, bit c = column c, row 0 first
//   kern_we/kern_data kernel write (LOAD only), bit i*K+j = row i, column j
//   mode              0 = AND popcount, 1 = XNOR match count
//   thresh            activation threshold (THRESH_EN builds)
//   out_valid/ready   result handshake
//   out_data, out_bit match count and thresholded activation
//   out_row, out_col  output position of the result
//   out_last          result is the final window (OH-1, OW-1)
//   busy              high while results are being produced
//   done              one-cycle pulse after the final result is consumed
// -----------------------------------------------------------------------------
module binconv_stream_engine
    import binconv_pkg::*;
#(
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int K     = 3,
    parameter int CW    = count_width(K)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           row_valid,
    output logic                           row_ready,
    input  logic [IMG_W-1:0]               row_data,
    input  logic                           kern_we,
    input  logic [K*K-1:0]                 kern_data,
    input  logic                           mode,
    input  logic [CW-1:0]                  thresh,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CW-1:0]                  out_data,
    output logic                           out_bit,
    output logic [$clog2(IMG_H-K+1)-1:0]   out_row,
    output logic [$clog2(IMG_W-K+1)-1:0]   out_col,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    localparam int OH  = IMG_H - K + 1;
    localparam int OW  = IMG_W - K + 1;
    localparam int RW  = $clog2(OH);
    localparam int CLW = $clog2(OW);
    localparam int HW  = $clog2(IMG_H);
    localparam int IW  = $clog2(IMG_W);

    state_t           state;
    state_t           state_next;

    logic [HW-1:0]    row_cnt;
    logic [IMG_W-1:0] img [IMG_H];
    logic [K*K-1:0]   kern_q;
    logic             mode_q;

    logic             row_acc;
    logic             last_row;
    logic             out_hs;

    // Next window to be presented and whether the final window was issued.
    logic [RW-1:0]    win_r;
    logic [CLW-1:0]   win_c;
    logic             issued_all;

    logic             load_p0;
    logic             at_end_p0;
    logic [K*K-1:0]   win_p0;
    logic [CW-1:0]    cnt_p0;
    logic [HW-1:0]    ri;
    logic [IW-1:0]    cj;

    // -------------------------------------------------------------------------
    // Handshake decode and FSM
    // -------------------------------------------------------------------------
    always_comb begin
        row_acc   = (state == LOAD) && row_valid;
        last_row  = row_acc && (row_cnt == HW'(IMG_H - 1));
        out_hs    = out_valid && out_ready;
        at_end_p0 = (win_r == RW'(OH - 1)) && (win_c == CLW'(OW - 1));
        // The output register refills when empty or being drained, giving one
        // result per cycle under continuous out_ready.
        load_p0   = (state == CONV) && !issued_all && (!out_valid || out_ready);
    end

    always_comb begin
        state_next = state;
        row_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            LOAD: begin
                row_ready = 1'b1;
                if (last_row) state_next = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (out_hs && out_last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    // -------------------------------------------------------------------------
    // Image, kernel and per-pass mode capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            kern_q  <= '0;
            mode_q  <= MODE_AND;
            for (int r = 0; r < IMG_H; r++) img[r] <= '0;
        end else begin
            if (row_acc) begin
                img[row_cnt] <= row_data;
                row_cnt      <= last_row ? '0 : row_cnt + HW'(1);
            end
            // Written in the same cycle as the final row, the new kernel is
            // already in place for the pass that follows.
            if ((state == LOAD) && kern_we) kern_q <= kern_data;
            if (last_row) mode_q <= mode;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p0: window gather and match count for position (win_r, win_c)
    // -------------------------------------------------------------------------
    always_comb begin
        win_p0 = '0;
        ri     = '0;
        cj     = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                ri = HW'(win_r) + HW'(i);
                cj = IW'(win_c) + IW'(j);
                win_p0[i*K+j] = img[ri][cj];
            end
        end
    end

    binconv_window_pop #(
        .K  (K),
        .CW (CW)
    ) u_pop (
        .win   (win_p0),
        .kern  (kern_q),
        .mode  (mode_q),
        .count (cnt_p0)
    );

`ifdef THRESH_EN
    logic [CW-1:0] thresh_q;

    always_ff @(posedge clk) begin
        if (rst)           thresh_q <= '0;
        else if (last_row) thresh_q <= thresh;
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign out_bit       = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Stage p1: output register and window position counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            win_r      <= '0;
            win_c      <= '0;
            issued_all <= 1'b0;
`ifdef THRESH_EN
            out_bit    <= 1'b0;
`endif
        end else if (last_row) begin
            win_r      <= '0;
            win_c      <= '0;
            issued_all <= 1'b0;
        end else if (load_p0) begin
            out_valid <= 1'b1;
            out_data  <= cnt_p0;
            out_row   <= win_r;
            out_col   <= win_c;
            out_last  <= at_end_p0;
`ifdef THRESH_EN
            out_bit   <= (cnt_p0 >= thresh_q);
`endif
            if (at_end_p0) begin
                issued_all <= 1'b1;
            end else if (win_c == CLW'(OW - 1)) begin
                win_c <= '0;
                win_r <= win_r + RW'(1);
            end else begin
                win_c <= win_c + CLW'(1);
            end
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_binconv_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_binconv_stream_engine
// Scoreboard bench for binconv_stream_engine: the driver loads images and
// kernels and pushes the expected result stream computed from a direct
// convolution model; a separate monitor pops and compares every handshake.
// -----------------------------------------------------------------------------
module tb_binconv_stream_engine;

    localparam int IMG_W = 6;
    localparam int IMG_H = 6;
    localparam int K     = 3;
    localparam int KK    = K * K;
    localparam int CW    = 4;
    localparam int OH    = IMG_H - K + 1;
    localparam int OW    = IMG_W - K + 1;
`ifdef THRESH_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             row_valid;
    logic             row_ready;
    logic [IMG_W-1:0] row_data;
    logic             kern_we;
    logic [KK-1:0]    kern_data;
    logic             mode;
    logic [CW-1:0]    thresh;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_data;
    logic             out_bit;
    logic [1:0]       out_row;
    logic [1:0]       out_col;
    logic             out_last;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    binconv_stream_engine #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .kern_we   (kern_we),
        .kern_data (kern_data),
        .mode      (mode),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bit   (out_bit),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int data;
        int b;
        int row;
        int col;
        int last;
    } res_t;

    res_t             exp_q[$];
    res_t             mon_e;
    res_t             held;
    logic [IMG_W-1:0] m_img [IMG_H];
    int               n_checks  = 0;
    int               n_fail    = 0;
    int               n_popped  = 0;
    bit               done_due  = 1'b0;
    bit               pass_done = 1'b0;
    bit               prev_stall = 1'b0;
    int               bp_mode   = 0;
    int               stalls    = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: direct evaluation of every output window.
    function automatic void push_expected(input logic [KK-1:0] kn, input logic md,
                                          input logic [CW-1:0] th);
        res_t e;
        for (int orow = 0; orow < OH; orow++) begin
            for (int ocol = 0; ocol < OW; ocol++) begin
                int cnt = 0;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        int a = int'(m_img[orow+i][ocol+j]);
                        int k = int'(kn[i*K+j]);
                        if (md) cnt += (a == k) ? 1 : 0;
                        else    cnt += a * k;
                    end
                end
                e.data = cnt;
                e.b    = (THR_EN && cnt >= int'(th)) ? 1 : 0;
                e.row  = orow;
                e.col  = ocol;
                e.last = (orow == OH - 1 && ocol == OW - 1) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
    endfunction

    // Monitor: checks done timing, backpressure hold and every result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                done_due   = 1'b0;
            end else begin
                chk("done_pulse", int'(done), int'(done_due));
                if (done_due && done) pass_done = 1'b1;
                done_due = 1'b0;
                if (prev_stall) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data",  int'(out_data), held.data);
                    chk("hold_bit",   int'(out_bit),  held.b);
                    chk("hold_row",   int'(out_row),  held.row);
                    chk("hold_col",   int'(out_col),  held.col);
                    chk("hold_last",  int'(out_last), held.last);
                end
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_result: got data %0d at (%0d,%0d), expected none",
                                 out_data, out_row, out_col);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("res_data", int'(out_data), mon_e.data);
                        chk("res_bit",  int'(out_bit),  mon_e.b);
                        chk("res_row",  int'(out_row),  mon_e.row);
                        chk("res_col",  int'(out_col),  mon_e.col);
                        chk("res_last", int'(out_last), mon_e.last);
                        n_popped++;
                        if (mon_e.last != 0) done_due = 1'b1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                held.data  = int'(out_data);
                held.b     = int'(out_bit);
                held.row   = int'(out_row);
                held.col   = int'(out_col);
                held.last  = int'(out_last);
            end
        end
    end

    // Consumer readiness: always, random, or a 3-cycle stall on result (1,2).
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 2 && out_valid && out_row == 2'd1 && out_col == 2'd2 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else if (bp_mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // kmode: 0 = write kernel before rows, 1 = with the final row, 2 = no write
    task automatic load_pass(input logic [KK-1:0] kn, input logic md,
                             input logic [CW-1:0] th, input int kmode, input bit gaps);
        int t;
        if (kmode == 0) begin
            kern_we   = 1'b1;
            kern_data = kn;
            @(posedge clk); #1;
            kern_we   = 1'b0;
            kern_data = KK'($urandom);
        end
        for (int r = 0; r < IMG_H; r++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                row_valid = 1'b0;
                @(posedge clk); #1;
            end
            row_valid = 1'b1;
            row_data  = m_img[r];
            if (r == IMG_H - 1) begin
                mode   = md;
                thresh = th;
                if (kmode == 1) begin
                    kern_we   = 1'b1;
                    kern_data = kn;
                end
            end
            t = 0;
            @(negedge clk);
            while (!row_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("row_ready_load", int'(row_ready), 1);
            @(posedge clk); #1;
            row_valid = 1'b0;
            kern_we   = 1'b0;
        end
        push_expected(kn, md, th);
        @(negedge clk);
        chk("busy_on_entry", int'(busy), 1);
        chk("valid_latency0", int'(out_valid), 0);
        @(negedge clk);
        chk("valid_latency1", int'(out_valid), 1);
    endtask

    task automatic finish_pass();
        int t = 0;
        while (!pass_done && t < 400) begin
            @(posedge clk);
            t++;
        end
        chk("pass_complete", int'(pass_done), 1);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        pass_done = 1'b0;
        #1;
    endtask

    task automatic stress_conv();
        @(posedge clk); #1;
        for (int n = 0; n < 6; n++) begin
            row_valid = 1'b1;
            row_data  = IMG_W'($urandom);
            kern_we   = 1'b1;
            kern_data = KK'($urandom);
            mode      = ~mode;
            thresh    = CW'($urandom);
            @(negedge clk);
            chk("row_ready_conv", int'(row_ready), 0);
            chk("busy_conv", int'(busy), 1);
            @(posedge clk); #1;
        end
        row_valid = 1'b0;
        kern_we   = 1'b0;
    endtask

    task automatic fill(input int pat);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                case (pat)
                    0:       m_img[r][c] = 1'b0;
                    1:       m_img[r][c] = 1'b1;
                    2:       m_img[r][c] = 1'((r + c) & 1);
                    default: m_img[r][c] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    endtask

    initial begin
        logic [KK-1:0] kr;
        int            target;
        int            t;
        rst       = 1'b1;
        row_valid = 1'b0;
        row_data  = '0;
        kern_we   = 1'b0;
        kern_data = '0;
        mode      = 1'b0;
        thresh    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_ready", int'(row_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data), 0);
        chk("rst_out_bit",   int'(out_bit), 0);
        chk("rst_out_row",   int'(out_row), 0);
        chk("rst_out_col",   int'(out_col), 0);
        chk("rst_out_last",  int'(out_last), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_done",      int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All ones, AND
        fill(1); load_pass('1, 1'b0, 4'd0, 0, 1'b0); finish_pass();
        // All zeros, XNOR then AND
        fill(0); load_pass('0, 1'b1, 4'd0, 0, 1'b0); finish_pass();
        load_pass('0, 1'b0, 4'd0, 2, 1'b0); finish_pass();
        // Centre-only kernel over a checkerboard, kernel written with final row
        fill(2); load_pass(9'b000010000, 1'b0, 4'd0, 1, 1'b0); finish_pass();
        // Three-cycle stall on result (1,2)
        bp_mode = 2; stalls = 0;
        load_pass(9'b000010000, 1'b0, 4'd0, 2, 1'b0); finish_pass();
        chk("stall_cycles", stalls, 3);
        // Random traffic with random consumer readiness
        bp_mode = 1;
        for (int n = 0; n < 6; n++) begin
            fill(3);
            load_pass(KK'($urandom), 1'($urandom_range(0, 1)), CW'($urandom_range(0, 10)),
                      $urandom_range(0, 1), 1'b1);
            finish_pass();
        end
        // Row and kernel writes during CONV are ignored; kernel persists after
        bp_mode = 0;
        fill(3); kr = KK'($urandom);
        load_pass(kr, 1'b1, 4'd5, 0, 1'b0); stress_conv(); finish_pass();
        load_pass(kr, 1'b1, 4'd5, 2, 1'b0); finish_pass();
        // Threshold edges
        fill(1);
        load_pass('1, 1'b0, 4'd9, 0, 1'b0); finish_pass();
        load_pass('1, 1'b0, 4'd10, 2, 1'b0); finish_pass();
        // Reset at result 5 aborts the pass
        fill(3);
        load_pass(KK'($urandom), 1'b0, 4'd3, 0, 1'b0);
        target = n_popped + 5;
        t = 0;
        while (n_popped < target && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("reach_result5", (n_popped >= target) ? 1 : 0, 1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_row_ready", int'(row_ready), 1);
        chk("abort_busy",      int'(busy), 0);
        chk("abort_done",      int'(done), 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
            chk("abort_idle_valid", int'(out_valid), 0);
        end
        @(posedge clk); #1;
        // Recovery pass after abort
        fill(3);
        load_pass(KK'($urandom), 1'b1, 4'd6, 1, 1'b1); finish_pass();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
